// File: rtl/fast_irq_pkg.sv
// Shared constants for the fast-interrupt controller: register byte offsets
// and the width of the core's fast-interrupt vector.
package fast_irq_pkg;

    localparam int FIRQ_MAX_SRC = 15;

    localparam logic [4:0] FIRQ_PENDING   = 5'h00;
    localparam logic [4:0] FIRQ_ENABLE    = 5'h04;
    localparam logic [4:0] FIRQ_TRIGGER   = 5'h08;
    localparam logic [4:0] FIRQ_CLAIM     = 5'h0C;
    localparam logic [4:0] FIRQ_INSERVICE = 5'h10;
    localparam logic [4:0] FIRQ_SWSET     = 5'h14;

endpackage

// File: rtl/fast_irq_gateway.sv
// Per-source interrupt gateway: synchronises one raw line and turns it into a
// pending-set request, either a one-cycle edge pulse or a gated level.
module fast_irq_gateway
    import fast_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic trigger,
    input  logic inservice,
    output logic set
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            prev_q <= synced;
        end
    end

    // Level requests are held off while in service so a completed source
    // re-pends only after software has finished with it.
    assign set = trigger ? (synced & ~prev_q) : (synced & ~inservice);

endmodule

// File: rtl/fast_irq_ctrl.sv
// Fast-interrupt controller: per-source gateways, pending/enable/in-service
// state, claim/complete over a req/gnt/rvalid bus, registered irq_fast_o.
module fast_irq_ctrl
    import fast_irq_pkg::*;
#(
    parameter int NUM_SRC     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      src_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [31:0]             rdata_o,
    output logic [FIRQ_MAX_SRC-1:0] irq_fast_o
);

    logic [NUM_SRC-1:0]      pending_q;
    logic [NUM_SRC-1:0]      enable_q;
    logic [NUM_SRC-1:0]      trigger_q;
    logic [NUM_SRC-1:0]      inservice_q;
    logic [NUM_SRC-1:0]      pending_n;
    logic [NUM_SRC-1:0]      inservice_n;
    logic [NUM_SRC-1:0]      gw_set;
    logic [NUM_SRC-1:0]      swset_bits;
    logic [NUM_SRC-1:0]      candidates;
    logic [FIRQ_MAX_SRC-1:0] irq_q;
    logic [4:0]              reg_off;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    claim_hit;
    logic [3:0]              claim_id;
    logic                    claim_take;
    logic [31:0]             rdata_n;
    logic                    rvalid_q;
    logic [31:0]             rdata_q;
    logic                    unused_addr;

    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    assign reg_off = {addr_i[4:2], 2'b00};
    assign rd_acc  = req_i & ~we_i;
    assign wr_acc  = req_i & we_i;
    assign gnt_o   = req_i;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        fast_irq_gateway #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_gw (
            .clk       (clk),
            .rst       (rst),
            .src       (src_i[g]),
            .trigger   (trigger_q[g]),
            .inservice (inservice_q[g]),
            .set       (gw_set[g])
        );
    end

    assign candidates = pending_q & enable_q & ~inservice_q;

    // Scan from the top so the lowest-index candidate is the one that sticks.
    always_comb begin
        claim_hit = 1'b0;
        claim_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                claim_hit = 1'b1;
                claim_id  = 4'(i);
            end
        end
    end

    assign claim_take = rd_acc && (reg_off == FIRQ_CLAIM) && claim_hit;
    assign swset_bits = (wr_acc && (reg_off == FIRQ_SWSET)) ? wdata_i[NUM_SRC-1:0] : '0;

    // Sets are OR-ed in last so a same-cycle gateway or SWSET set wins over
    // the claim clear.
    always_comb begin
        pending_n   = pending_q;
        inservice_n = inservice_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim_take && (claim_id == 4'(i))) begin
                pending_n[i]   = 1'b0;
                inservice_n[i] = 1'b1;
            end
            if (wr_acc && (reg_off == FIRQ_CLAIM) && (wdata_i == 32'(i + 1))) begin
                inservice_n[i] = 1'b0;
            end
        end
        pending_n = pending_n | gw_set | swset_bits;
    end

    always_comb begin
        rdata_n = 32'd0;
        case (reg_off)
            FIRQ_PENDING:   rdata_n = 32'(pending_q);
            FIRQ_ENABLE:    rdata_n = 32'(enable_q);
            FIRQ_TRIGGER:   rdata_n = 32'(trigger_q);
            FIRQ_CLAIM:     rdata_n = claim_hit ? ({28'd0, claim_id} + 32'd1) : 32'd0;
            FIRQ_INSERVICE: rdata_n = 32'(inservice_q);
            default:        rdata_n = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            enable_q    <= '0;
            trigger_q   <= '0;
            inservice_q <= '0;
            irq_q       <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            pending_q   <= pending_n;
            inservice_q <= inservice_n;
            if (wr_acc && (reg_off == FIRQ_ENABLE)) begin
                enable_q <= wdata_i[NUM_SRC-1:0];
            end
            if (wr_acc && (reg_off == FIRQ_TRIGGER)) begin
                trigger_q <= wdata_i[NUM_SRC-1:0];
            end
            irq_q    <= FIRQ_MAX_SRC'(candidates);
            rvalid_q <= req_i;
            rdata_q  <= rd_acc ? rdata_n : 32'd0;
        end
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign irq_fast_o = irq_q;

endmodule
